vga_timing_gen: RTL and testbench

Raster timing generator for the 640x480@60 Hz VGA path. Divides the system clock down to a pixel-tick enable. Produces the `h_cnt`/`v_cnt` scan counters consumed by the downstream pixel-address generators, plus the visible-region flag, sync pulses and frame/line markers. Sits directly upstream of address generation and block-RAM readout; sync/valid outputs can be delayed to line up with that downstream latency.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480@60 Hz VGA path: pixel-tick divider, scan counters, sync/valid decodes and line/frame markers.
// Define VGA_PIPE_ALIGN_EN to delay valid/hsync/vsync by PIPE_DEPTH pixel ticks so they line up with address-gen plus BRAM readout.
module vga_timing_gen #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter int   CLK_DIV    = 4,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             h_wrap;
    logic             v_wrap;
    logic             valid_dec;
    logic             hsync_dec;
    logic             vsync_dec;

    // Gated by rst so the strobe stays low in reset even when CLK_DIV is 1.
    assign pclk_en = !rst && (div == DIV_LAST);
    assign h_wrap  = (h_cnt == H_LAST);
    assign v_wrap  = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pclk_en && h_wrap;
            frame_start <= pclk_en && h_wrap && v_wrap;
            if (pclk_en) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        valid_dec = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_dec = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        vsync_dec = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    end

`ifdef VGA_PIPE_ALIGN_EN
    logic [PIPE_DEPTH-1:0] valid_pipe;
    logic [PIPE_DEPTH-1:0] hsync_pipe;
    logic [PIPE_DEPTH-1:0] vsync_pipe;

    // Stages advance only on pixel ticks, so the lag is counted in pixels, not clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
            hsync_pipe <= {PIPE_DEPTH{~SYNC_POL}};
            vsync_pipe <= {PIPE_DEPTH{~SYNC_POL}};
        end else if (pclk_en) begin
            valid_pipe[0] <= valid_dec;
            hsync_pipe[0] <= hsync_dec;
            vsync_pipe[0] <= vsync_dec;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                hsync_pipe[i] <= hsync_pipe[i-1];
                vsync_pipe[i] <= vsync_pipe[i-1];
            end
        end
    end

    assign valid = valid_pipe[PIPE_DEPTH-1];
    assign hsync = hsync_pipe[PIPE_DEPTH-1];
    assign vsync = vsync_pipe[PIPE_DEPTH-1];
`else
    assign valid = valid_dec;
    assign hsync = hsync_dec;
    assign vsync = vsync_dec;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a reference raster model queues expected outputs per clock, compared at the falling edge.
// Uses a shrunken raster so several frames, a mid-frame reset and frame-period measurements fit in a short run.
module tb_vga_timing_gen;

    localparam int   HV = 20, HF = 4, HS = 6, HB = 3;
    localparam int   VV = 8,  VF = 2, VS = 2, VB = 3;
    localparam int   CD = 4;
    localparam logic SP = 1'b0;
    localparam int   PD = 2;
    localparam int   HT = HV + HF + HS + HB;
    localparam int   VT = VV + VF + VS + VB;
    localparam int   NUM_CYCLES = 9500;

    logic       clk = 1'b0;
    logic       rst;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    typedef struct {
        logic pe;
        int   h;
        int   v;
        logic valid;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int            m_div, m_h, m_v, m_frames;
    logic          m_ls, m_fs;
    logic [PD-1:0] m_vpipe, m_hpipe, m_spipe;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(CD), .SYNC_POL(SP), .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk), .rst(rst), .pclk_en(pclk_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid(valid), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start)
    );

    function automatic logic dec_valid(input int h, input int v);
        return (h < HV) && (v < VV);
    endfunction

    function automatic logic dec_hs(input int h);
        return (h >= HV + HF && h <= HV + HF + HS - 1) ? SP : ~SP;
    endfunction

    function automatic logic dec_vs(input int v);
        return (v >= VV + VF && v <= VV + VF + VS - 1) ? SP : ~SP;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Drives rst for the next rising edge, advances the reference model across that edge and queues what the DUT should show after it.
    task automatic applyStimulus(input logic r);
        exp_t e;
        logic pe;
        rst = r;
        if (r) begin
            m_div = 0; m_h = 0; m_v = 0; m_ls = 1'b0; m_fs = 1'b0;
            m_vpipe = '0; m_hpipe = {PD{~SP}}; m_spipe = {PD{~SP}};
        end else begin
            pe = (m_div == CD - 1);
            m_ls = 1'b0;
            m_fs = 1'b0;
            if (pe) begin
                m_vpipe = {m_vpipe[PD-2:0], dec_valid(m_h, m_v)};
                m_hpipe = {m_hpipe[PD-2:0], dec_hs(m_h)};
                m_spipe = {m_spipe[PD-2:0], dec_vs(m_v)};
                if (m_h == HT - 1) begin
                    m_ls = 1'b1;
                    m_fs = (m_v == VT - 1);
                    m_h  = 0;
                    m_v  = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
                if (m_fs) m_frames++;
            end
            m_div = pe ? 0 : m_div + 1;
        end
        e.pe = !r && (m_div == CD - 1);
        e.h  = m_h;
        e.v  = m_v;
        e.ls = m_ls;
        e.fs = m_fs;
`ifdef VGA_PIPE_ALIGN_EN
        e.valid = m_vpipe[PD-1];
        e.hs    = m_hpipe[PD-1];
        e.vs    = m_spipe[PD-1];
`else
        e.valid = dec_valid(m_h, m_v);
        e.hs    = dec_hs(m_h);
        e.vs    = dec_vs(m_v);
`endif
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic r;
        int   last_fs  = -1;
        int   hs_run   = 0;
        int   vs_run   = 0;
        int   periods  = 0;
        int   mid_left = 0;
        bit   mid_done = 0;

        m_frames = 0;
        applyStimulus(1'b1);
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pclk_en",     32'(pclk_en),     32'(e.pe));
                checkOutput("h_cnt",       32'(h_cnt),       32'(e.h));
                checkOutput("v_cnt",       32'(v_cnt),       32'(e.v));
                checkOutput("valid",       32'(valid),       32'(e.valid));
                checkOutput("hsync",       32'(hsync),       32'(e.hs));
                checkOutput("vsync",       32'(vsync),       32'(e.vs));
                checkOutput("line_start",  32'(line_start),  32'(e.ls));
                checkOutput("frame_start", 32'(frame_start), 32'(e.fs));
            end

            // Independent measurements of pulse widths and frame period from what the DUT shows.
            if (rst) begin
                last_fs = -1;
                hs_run  = 0;
                vs_run  = 0;
            end else begin
                if (frame_start) begin
                    if (last_fs >= 0) begin
                        checkOutput("frame_period_clks", 32'(cyc - last_fs), 32'(HT * VT * CD));
                        periods++;
                    end
                    last_fs = cyc;
                end
                if (hsync == SP) hs_run++;
                else if (hs_run > 0) begin
                    checkOutput("hsync_width_clks", 32'(hs_run), 32'(HS * CD));
                    hs_run = 0;
                end
                if (vsync == SP) vs_run++;
                else if (vs_run > 0) begin
                    checkOutput("vsync_width_clks", 32'(vs_run), 32'(VS * HT * CD));
                    vs_run = 0;
                end
            end

            // Three reset edges at start, then a two-edge reset mid-frame while pclk_en is low.
            if (cyc < 2) begin
                r = 1'b1;
            end else if (mid_left > 0) begin
                r = 1'b1;
                mid_left--;
            end else if (!mid_done && m_frames >= 1 && m_h == 17 && m_v == 6 && m_div == 1) begin
                r = 1'b1;
                mid_done = 1;
                mid_left = 1;
                $display("[TB] Mid-frame reset at h=%0d v=%0d", m_h, m_v);
            end else begin
                r = 1'b0;
            end
            applyStimulus(r);
        end

        checkOutput("mid_reset_applied", 32'(mid_done), 32'd1);
        checkOutput("frame_periods_measured", 32'(periods >= 2), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
